// File: rtl/ahb_bram_slave_pkg.sv
// Shared AHB-Lite codes, FSM state type and the size/alignment helpers for
// the block-RAM slave.
package ahb_bram_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_RDATA,
    ST_STALL,
    ST_ERR1,
    ST_ERR2
  } state_t;

  function automatic logic size_legal(input logic [2:0] size, input logic [1:0] lsb);
    case (size)
      HSIZE_BYTE: return 1'b1;
      HSIZE_HALF: return !lsb[0];
      HSIZE_WORD: return lsb == 2'b00;
      default:    return 1'b0;
    endcase
  endfunction

  // Little-endian byte lanes; illegal sizes yield no lanes at all.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lsb);
    logic [3:0] m;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << lsb;
      HSIZE_HALF: m = lsb[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: m = '1;
      default:    m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahb_bram_slave_if.sv
// AHB-Lite bus signals seen by the block-RAM slave.
interface ahb_bram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HREADY, HWDATA,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_bram_slave.sv
// AHB-Lite slave in front of a 32-bit block RAM: byte-lane writes, one-cycle
// reads, a single wait state on read-after-write to the same word, ERROR response.
module ahb_bram_slave
  import ahb_bram_slave_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_bram_slave_if.slave       ahb,
  output logic [ADDR_WIDTH-1:0] BRAM_RDADDR,
  input  logic [31:0]           BRAM_RDATA,
  output logic [ADDR_WIDTH-1:0] BRAM_WRADDR,
  output logic [31:0]           BRAM_WDATA,
  output logic [3:0]            BRAM_WE
);

  state_t                state;
  state_t                nxt;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [3:0]            reg_mask;
  logic                  hreadyout_q;
  logic                  hresp_q;
  logic                  accept;
  logic                  take;
  logic                  legal;
  logic                  collide;
  logic                  unused_haddr;

  assign in_addr = ahb.HADDR[ADDR_WIDTH+1:2];
  assign unused_haddr = ^ahb.HADDR[31:ADDR_WIDTH+2];

  assign accept = ahb.HSEL && ahb.HREADY &&
                  ((ahb.HTRANS == HTRANS_NONSEQ) || (ahb.HTRANS == HTRANS_SEQ));
  // Address phases presented during STALL/ERR1 are never taken, whatever HREADY says.
  assign take    = accept && (state != ST_STALL) && (state != ST_ERR1);
  assign legal   = size_legal(ahb.HSIZE, ahb.HADDR[1:0]);
  // The RAM write lands on this edge, so a same-word read would see stale data.
  assign collide = (state == ST_WDATA) && (in_addr == reg_addr);

  always_comb begin
    nxt = ST_IDLE;
    case (state)
      ST_STALL: nxt = ST_RDATA;
      ST_ERR1:  nxt = ST_ERR2;
      default: begin
        if (take) begin
          if (!legal)           nxt = ST_ERR1;
          else if (ahb.HWRITE)  nxt = ST_WDATA;
          else if (collide)     nxt = ST_STALL;
          else                  nxt = ST_RDATA;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state       <= ST_IDLE;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      reg_addr    <= '0;
      reg_mask    <= '0;
    end else begin
      state       <= nxt;
      hreadyout_q <= (nxt != ST_STALL) && (nxt != ST_ERR1);
      hresp_q     <= ((nxt == ST_ERR1) || (nxt == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      if (take) begin
        reg_addr <= in_addr;
        reg_mask <= lane_mask(ahb.HSIZE, ahb.HADDR[1:0]);
      end
    end
  end

  assign ahb.HREADYOUT = hreadyout_q;
  assign ahb.HRESP     = hresp_q;
  assign ahb.HRDATA    = (state == ST_RDATA) ? BRAM_RDATA : '0;

  assign BRAM_RDADDR = (state == ST_STALL) ? reg_addr : in_addr;
  assign BRAM_WRADDR = reg_addr;
  assign BRAM_WDATA  = ahb.HWDATA;
  // Write strobes drop immediately when reset is asserted, not one edge later.
  assign BRAM_WE     = ((state == ST_WDATA) && HRESETn) ? reg_mask : '0;

endmodule

// File: tb/tb_ahb_bram_slave.sv
// Scoreboard bench for ahb_bram_slave: directed scenarios followed by random
// AHB traffic, checked against a byte-level memory reference model.
module tb_ahb_bram_slave;
  import ahb_bram_slave_pkg::*;

  localparam int unsigned AW    = 12;
  localparam int unsigned DEPTH = 1 << AW;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_bram_slave_if bus ();
  assign bus.HREADY = bus.HREADYOUT;

  logic [AW-1:0] rdaddr;
  logic [AW-1:0] wraddr;
  logic [31:0]   rdata_ram = '0;
  logic [31:0]   wdata_ram;
  logic [3:0]    we;

  ahb_bram_slave #(.ADDR_WIDTH(AW)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .ahb         (bus),
    .BRAM_RDADDR (rdaddr),
    .BRAM_RDATA  (rdata_ram),
    .BRAM_WRADDR (wraddr),
    .BRAM_WDATA  (wdata_ram),
    .BRAM_WE     (we)
  );

  // Read-first block RAM with one cycle of read latency.
  logic [31:0] ram [DEPTH] = '{default: '0};
  always @(posedge HCLK) begin
    rdata_ram <= ram[rdaddr];
    ram[wraddr] <= (ram[wraddr] & ~{{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}})
                 | (wdata_ram   &  {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}});
  end

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] rdata;
    logic [3:0]  we;
    int unsigned waits;
  } exp_t;

  exp_t          expq[$];
  logic [31:0]   model [DEPTH];
  int            checks = 0;
  int            errors = 0;
  logic [31:0]   pend_wdata;
  bit            prev_wr_valid;
  logic [AW-1:0] prev_wr_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_sim();
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  function automatic bit legal_m(input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] bytes;
    bytes = 32'd1 << size;
    return (size <= 3'd2) && ((addr % bytes) == 32'd0);
  endfunction

  function automatic logic [3:0] mask_m(input logic [31:0] addr, input logic [2:0] size);
    logic [3:0]  m;
    logic [31:0] bytes;
    logic [31:0] lo;
    m = '0;
    bytes = 32'd1 << size;
    lo = addr % 32'd4;
    for (logic [31:0] b = 0; b < bytes; b++) m = m | (4'b0001 << (lo + b));
    return m;
  endfunction

  // One address phase; returns right after the edge on which it was accepted.
  task automatic phase(input bit sel, input logic [1:0] trans, input logic [31:0] addr,
                       input logic [2:0] size, input bit wr, input logic [31:0] wdata,
                       input bit commit);
    exp_t          e;
    bit            r;
    int            n;
    logic [AW-1:0] word;
    logic [31:0]   bm;
    bus.HWDATA = pend_wdata;
    bus.HSEL   = sel;
    bus.HTRANS = trans;
    bus.HADDR  = addr;
    bus.HSIZE  = size;
    bus.HWRITE = wr;
    word = AW'(addr >> 2);
    if (sel && trans[1]) begin
      e.err   = !legal_m(addr, size);
      e.rd    = !wr;
      e.we    = '0;
      e.rdata = '0;
      e.waits = e.err ? 1 : 0;
      if (!e.err && wr) begin
        e.we = mask_m(addr, size);
        bm = {{8{e.we[3]}}, {8{e.we[2]}}, {8{e.we[1]}}, {8{e.we[0]}}};
        if (commit) model[word] = (model[word] & ~bm) | (wdata & bm);
      end
      if (!e.err && !wr) begin
        e.rdata = model[word];
        if (prev_wr_valid && prev_wr_word == word) e.waits = 1;
      end
      prev_wr_valid = !e.err && wr;
      prev_wr_word  = word;
      if (commit) expq.push_back(e);
    end else begin
      prev_wr_valid = 1'b0;
    end
    pend_wdata = wdata;
    n = 0;
    do begin
      @(negedge HCLK);
      r = bus.HREADYOUT;
      @(posedge HCLK);
      #1;
      n++;
    end while (!r && n < 16);
    if (!r) begin
      errors++;
      $display("FAIL bus_timeout: HREADYOUT still low after %0d cycles, required high within 16", n);
      finish_sim();
    end
  endtask

  task automatic idle();
    phase(1'b0, HTRANS_IDLE, $urandom, HSIZE_WORD, 1'b0, $urandom, 1'b1);
  endtask

  // Reset pulse landing in the data phase of the write issued just before.
  task automatic reset_mid();
    bus.HWDATA = pend_wdata;
    bus.HSEL   = 1'b0;
    bus.HTRANS = HTRANS_IDLE;
    HRESETn    = 1'b0;
    @(posedge HCLK);
    #1;
    HRESETn       = 1'b1;
    prev_wr_valid = 1'b0;
    pend_wdata    = '0;
  endtask

  initial begin : monitor
    bit          dp;
    bit          acc;
    int unsigned waits;
    exp_t        h;
    dp = 1'b0;
    waits = 0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        chk("we_during_reset", {28'b0, we}, 32'd0);
        expq.delete();
        dp = 1'b0;
        waits = 0;
      end else begin
        acc = bus.HSEL && bus.HTRANS[1] && bus.HREADY;
        if (!dp) begin
          chk("idle_hreadyout", {31'b0, bus.HREADYOUT}, 32'd1);
          chk("idle_hresp", {31'b0, bus.HRESP}, 32'd0);
          chk("idle_hrdata", bus.HRDATA, 32'd0);
          chk("idle_we", {28'b0, we}, 32'd0);
        end else if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_data_phase: scoreboard empty at %0t", $time);
          dp = 1'b0;
        end else begin
          h = expq[0];
          chk("bram_we", {28'b0, we}, {28'b0, h.we});
          chk("hresp", {31'b0, bus.HRESP}, {31'b0, h.err});
          if (!bus.HREADYOUT) begin
            chk("hrdata_in_wait", bus.HRDATA, 32'd0);
            waits++;
          end else begin
            chk("hrdata", bus.HRDATA, (h.rd && !h.err) ? h.rdata : 32'd0);
            chk("wait_states", waits, h.waits);
            void'(expq.pop_front());
            waits = 0;
          end
        end
        if (bus.HREADYOUT) dp = acc;
      end
    end
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_sim();
  end

  initial begin : driver
    logic [31:0] w;
    logic [31:0] a;
    logic [2:0]  sz;
    logic [1:0]  tr;
    int unsigned k;
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = HTRANS_IDLE; bus.HSIZE = HSIZE_WORD;
    bus.HWRITE = 1'b0; bus.HWDATA = '0;
    pend_wdata = '0;
    prev_wr_valid = 1'b0;
    prev_wr_word = '0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    phase(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b1, 32'hDEADBEEF, 1'b1);
    phase(1'b1, HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 1'b0, $urandom, 1'b1);
    phase(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b0, $urandom, 1'b1);
    idle();

    w = $urandom; w[31:24] = 8'h11;
    phase(1'b1, HTRANS_NONSEQ, 32'h3, HSIZE_BYTE, 1'b1, w, 1'b1);
    w = $urandom; w[23:16] = 8'h22;
    phase(1'b1, HTRANS_NONSEQ, 32'h2, HSIZE_BYTE, 1'b1, w, 1'b1);
    phase(1'b1, HTRANS_NONSEQ, 32'h0, HSIZE_WORD, 1'b0, $urandom, 1'b1);
    idle();

    phase(1'b1, HTRANS_NONSEQ, 32'h40, HSIZE_WORD, 1'b1, 32'hA5A5A5A5, 1'b1);
    phase(1'b1, HTRANS_NONSEQ, 32'h40, HSIZE_WORD, 1'b0, $urandom, 1'b1);
    idle();

    phase(1'b1, HTRANS_NONSEQ, 32'h1, HSIZE_HALF, 1'b1, $urandom, 1'b1);
    phase(1'b1, HTRANS_NONSEQ, 32'h2, HSIZE_WORD, 1'b1, $urandom, 1'b1);
    phase(1'b1, HTRANS_NONSEQ, 32'h0, 3'd3, 1'b0, $urandom, 1'b1);
    phase(1'b1, HTRANS_NONSEQ, 32'h40, HSIZE_WORD, 1'b0, $urandom, 1'b1);
    idle();

    phase(1'b1, HTRANS_NONSEQ, 32'h100, HSIZE_WORD, 1'b1, $urandom, 1'b1);
    phase(1'b1, HTRANS_SEQ,    32'h104, HSIZE_WORD, 1'b1, $urandom, 1'b1);
    phase(1'b1, HTRANS_SEQ,    32'h108, HSIZE_WORD, 1'b1, $urandom, 1'b1);
    phase(1'b1, HTRANS_NONSEQ, 32'h100, HSIZE_WORD, 1'b0, $urandom, 1'b1);
    phase(1'b1, HTRANS_SEQ,    32'h104, HSIZE_WORD, 1'b0, $urandom, 1'b1);
    phase(1'b1, HTRANS_SEQ,    32'h108, HSIZE_WORD, 1'b0, $urandom, 1'b1);
    idle();

    phase(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b1, 32'h12345678, 1'b0);
    reset_mid();
    phase(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b0, $urandom, 1'b1);
    idle();

    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 9);
      tr = (k == 0) ? HTRANS_IDLE : (k == 1) ? HTRANS_BUSY :
           (k < 6) ? HTRANS_NONSEQ : HTRANS_SEQ;
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 31));
      if (sz <= 3'd2 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 3) == 0) begin
        w = $urandom;
        a[31:14] = w[17:0];
      end
      phase($urandom_range(0, 9) != 0, tr, a, sz, 1'($urandom_range(0, 1)), $urandom, 1'b1);
    end

    repeat (3) idle();
    finish_sim();
  end

endmodule

// File: doc/ahb_bram_slave.md
Name: ahb_bram_slave

Overview:
AHB-Lite slave that fronts a single-port-read / single-port-write 32-bit block RAM in the TD design. It registers the address phase and checks HSIZE/HADDR alignment. It computes the per-byte write lanes, drives the RAM write in the data phase, and returns read data. It also inserts wait states for read-after-write collisions and generates the two-cycle AHB ERROR response for illegal accesses.

Parameters:
ADDR_WIDTH, 12, RAM word-address bits (RAM depth = 2^ADDR_WIDTH words); HADDR bits above ADDR_WIDTH+1 ignored (aliasing)

Ports:
HCLK  input  1  system clock, all logic on rising edge
HRESETn  input  1  synchronous active-low reset
HSEL  input  1  slave select
HADDR  input  32  byte address
HTRANS  input  2  transfer type; only NONSEQ(2'b10)/SEQ(2'b11) start transfers
HSIZE  input  3  0=byte, 1=halfword, 2=word, others illegal
HWRITE  input  1  1=write
HREADY  input  1  bus-wide ready (address phase accepted only when high)
HWDATA  input  32  write data, valid in data phase
HREADYOUT  output  1  slave ready
HRESP  output  1  0=OKAY, 1=ERROR
HRDATA  output  32  read data
BRAM_RDADDR  output  ADDR_WIDTH  RAM read word address; RAM returns data one cycle later
BRAM_RDATA  input  32  RAM read data
BRAM_WRADDR  output  ADDR_WIDTH  RAM write word address
BRAM_WDATA  output  32  RAM write data
BRAM_WE  output  4  per-byte write enable, bit i = HWDATA[8i+7:8i]

Behaviour:
- Accept = HSEL & HTRANS[1] & HREADY.
- Legal = HSIZE==0, or HSIZE==1 & HADDR[0]==0, or HSIZE==2 & HADDR[1:0]==0.
- Lane mask, little-endian:
  - word -> 4'b1111
  - half at addr[1]=0/1 -> 4'b0011/4'b1100
  - byte at addr[1:0]=n -> 1<<n
- Registered on accept: word addr = HADDR[ADDR_WIDTH+1:2], lane mask, write flag, legal flag.
- States: IDLE, WDATA, RDATA, STALL, ERR1, ERR2.
- IDLE:
  - accept & !legal -> ERR1
  - legal write -> WDATA
  - legal read -> RDATA, or STALL if a collision is detected (see STALL)
- WDATA (zero wait):
  - BRAM_WE = stored mask, BRAM_WRADDR = stored addr, BRAM_WDATA = HWDATA; HREADYOUT=1.
  - Next state from the same-cycle accept (pipelined back-to-back).
- RDATA: HRDATA = BRAM_RDATA, HREADYOUT=1; next state from the same-cycle accept.
- BRAM_RDADDR = HADDR word bits every cycle, except in STALL, where it is the stored read address.
- Collision: read accepted while in WDATA with word addr == stored write addr (any lanes) -> STALL.
  - STALL: HREADYOUT=0, HRDATA=0; re-presents the stored read address.
  - Then -> RDATA, returning the post-write data.
  - Total read latency = 1 wait state.
- ERR1: HREADYOUT=0, HRESP=1. ERR2: HREADYOUT=1, HRESP=1, then normal decode of the same-cycle accept.
  - Illegal accesses never assert BRAM_WE.
- HRESP=0 in all states except ERR1/ERR2.
- HRDATA=32'h0 outside RDATA.
- HTRANS IDLE/BUSY or HSEL=0: no state change from IDLE; an active data phase still completes.
- No new accept while HREADYOUT=0: HREADY is low on the bus, so accept is false by protocol. Regardless, the block ignores the address phase in STALL/ERR1.
- Reset (HRESETn low at edge), including mid-operation:
  - Outputs: state IDLE, HREADYOUT=1, HRESP=0, BRAM_WE=0, HRDATA=0.
  - Any in-flight write is dropped; BRAM_WE is forced 0 in any cycle HRESETn is low.
- Reads never modify RAM. Write-then-write to the same word needs no stall.

Decomposition:
- Shared header (`include): HTRANS codes, HSIZE codes, HRESP codes, state encoding localparams.
- Lane-mask and legality logic is a small function in the same header; no sub-module required.
- Optional sub-module ahb_err_resp (two-state ERROR sequencer) if the header is reused by other slaves.

Test Plan:
- Word write 0xDEADBEEF @0x10, then word read @0x20, then read @0x10 -> BRAM_WE=4'b1111 in data phase; the read @0x10 returns 0xDEADBEEF with HREADYOUT=1 and no waits.
- Byte writes 0x11@0x3, 0x22@0x2 over a word previously 0x00000000, then word read @0x0 -> BRAM_WE 4'b1000 then 4'b0100; read 0x11220000.
- Write word 0xA5A5A5A5 @0x40 immediately followed by read @0x40 -> exactly one HREADYOUT=0 cycle; HRDATA=0xA5A5A5A5; HRESP=0.
- Halfword @0x1, word @0x2, HSIZE=3 @0x0 -> each gives HREADYOUT 0 then 1 with HRESP=1 both cycles; BRAM_WE stays 0; the next legal transfer proceeds normally.
- Back-to-back writes @0x0,0x4,0x8 (SEQ) then reads -> zero wait states on writes; all data correct.
- HRESETn low during a write data phase -> BRAM_WE=0 that cycle; HREADYOUT=1, HRESP=0 next cycle; the word is unchanged on readback.
